// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
// Holds the FSM state encoding, the requester ids and the default widths.
package dmem_arb_pkg;

    // Default widths for the 256 x 8 data memory.
    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;

    // Arbiter FSM: IDLE picks a winner, ACCESS drives the memory for one
    // cycle, RESP returns the ack for one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester ids, also used as the bit index into the request vector.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way pick.
// A lone requester always wins; on a tie the requester that was not granted
// last wins, unless fixed_prio is set, in which case the CPU wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,         // req[REQ_CPU], req[REQ_DMA]
    input  logic       last_grant,  // id of the previous winner
    input  logic       fixed_prio,  // 1: CPU wins every tie
    output logic       grant,       // winner id, meaningful when valid
    output logic       valid        // at least one request pending
);

    // Winner selection from the pending request pair.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        grant = REQ_CPU;
        valid = |req;
        case (req)
            2'b01:   grant = REQ_CPU;
            2'b10:   grant = REQ_DMA;
            2'b11:   grant = fixed_prio ? REQ_CPU : ~last_grant;
            default: grant = REQ_CPU;
        endcase
    end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU and DMA accesses onto the single-port
// 256 x 8 data memory with a req/ack handshake.
// Each access takes three cycles: IDLE (sample and latch the winner),
// ACCESS (drive the memory), RESP (one-cycle ack to the winner).
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give the CPU every tie
// (the DMA can then starve); left undefined, ties are round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_t        state;
    arb_state_t        state_next;

    // Request captured in IDLE; the access in flight uses only these copies,
    // so a requester changing its inputs afterwards cannot disturb it.
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              last_grant;

    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              pick_grant;
    logic              pick_valid;
    logic              latch_en;
    logic              capture_en;
    logic              in_access;
    logic              in_resp;

    rr_pick2 u_pick (
        .req        ({dma_req, cpu_req}),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        in_access  = 1'b0;
        in_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    latch_en   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                in_access  = 1'b1;
                capture_en = ~lat_we;
                state_next = RESP;
            end
            RESP: begin
                in_resp    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winning request and remember who was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_id     <= REQ_CPU;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= REQ_DMA;
        end else if (latch_en) begin
            lat_id     <= pick_grant;
            last_grant <= pick_grant;
            if (pick_grant == REQ_CPU) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end else begin
                lat_we    <= dma_we;
                lat_addr  <= dma_addr;
                lat_wdata <= dma_wdata;
            end
        end
    end

    // Capture read data into the winner's register on the edge ending ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (capture_en) begin
            if (lat_id == REQ_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end else begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory drive: only during ACCESS; reset kills a write in flight.
    assign mem_we    = in_access & lat_we & ~reset;
    assign mem_addr  = in_access ? lat_addr  : '0;
    assign mem_wdata = in_access ? lat_wdata : '0;

    // Handshake outputs, held at zero while reset is asserted.
    assign cpu_ack   = in_resp & (lat_id == REQ_CPU) & ~reset;
    assign dma_ack   = in_resp & (lat_id == REQ_DMA) & ~reset;
    assign busy      = (in_access | in_resp) & ~reset;
    assign cpu_rdata = reset ? '0 : cpu_rdata_q;
    assign dma_rdata = reset ? '0 : dma_rdata_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Drivers push the expected rdata of each access into a per-port queue when
// they issue it; a negedge monitor pops and compares on every ack.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam int NC = FIXED ? 3 : 2;   // CPU accesses in the contention test
    localparam int ND = FIXED ? 1 : 2;   // DMA accesses in the contention test

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_ack, dma_ack;
    logic [7:0] cpu_rdata, dma_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int we_cnt = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         mem_loaded = 1'b0;
    logic [7:0] last_rd [2];
    logic [7:0] cpu_q [$];
    logic [7:0] dma_q [$];

    typedef struct {
        bit port;
        int cyc;
    } ack_ev_t;
    ack_ev_t ack_log [$];
    bit      exp_order [$];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        return (i == 8'h30) ? 8'h00 : 8'((i * 7) + 3);
    endfunction

    // Memory model: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: score every ack against the expected queue of its port.
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (cpu_ack || dma_ack) begin
            check("ack_exclusive", 32'(cpu_ack & dma_ack), 0);
            check("busy_in_resp", 32'(busy), 1);
            if (cpu_ack) begin
                ack_log.push_back('{port: REQ_CPU, cyc: cyc});
                if (cpu_q.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 0);
                else check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
            end
            if (dma_ack) begin
                ack_log.push_back('{port: REQ_DMA, cyc: cyc});
                if (dma_q.size() == 0) check("dma_ack_unexpected", 32'(dma_ack), 0);
                else check("dma_rdata", 32'(dma_rdata), 32'(dma_q.pop_front()));
            end
        end
    end

    // Issue one access (caller is at a negedge), wait for its ack; with keep
    // the request stays high so the caller can present the next one.
    task automatic do_access(input bit port, input bit we, input logic [7:0] addr,
                             input logic [7:0] wdata, input bit keep, output int lat);
        logic [7:0] exp;
        int         start;
        bit         got;
        if (we) begin
            exp           = last_rd[port];
            ref_mem[addr] = wdata;
        end else begin
            exp           = ref_mem[addr];
            last_rd[port] = exp;
        end
        if (port == REQ_CPU) begin
            cpu_q.push_back(exp);
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dma_q.push_back(exp);
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end
        start = cyc;
        got   = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (port == REQ_CPU) ? cpu_ack : dma_ack;
        end
        lat = cyc - start;
        if (!got) check(port ? "dma_ack_timeout" : "cpu_ack_timeout", 32'(got), 1);
        if (!keep) begin
            if (port == REQ_CPU) cpu_req = 1'b0;
            else                 dma_req = 1'b0;
        end
    endtask

    task automatic hold_n(input bit port, input logic [7:0] addr, input int n);
        int lat;
        for (int i = 0; i < n; i++) do_access(port, 1'b0, addr, 8'h00, (i < n - 1), lat);
    endtask

    task automatic rand_port(input bit port, input int n);
        int         lat;
        bit         keep;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            a    = {port, 1'b1, 6'($urandom_range(0, 63))};
            w    = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            keep = (i < n - 1) && ($urandom_range(0, 3) == 0);
            do_access(port, w, a, d, keep, lat);
`ifndef DMEM_ARB_FIXED_PRIO_EN
            check(port ? "dma_wait_bound" : "cpu_wait_bound", 32'(lat <= 6), 1);
`endif
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // Grant order when both requesters keep re-requesting.
    task automatic build_order(input int nc, input int nd);
        bit last = REQ_DMA;
        bit win;
        exp_order.delete();
        while (nc > 0 || nd > 0) begin
            if (nc > 0 && nd > 0) win = FIXED ? REQ_CPU : ~last;
            else                  win = (nc > 0) ? REQ_CPU : REQ_DMA;
            exp_order.push_back(win);
            if (win == REQ_CPU) nc--; else nd--;
            last = win;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int t0;
        int w0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_dma_ack", 32'(dma_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_dma_rdata", 32'(dma_rdata), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_mem_addr", 32'(mem_addr), 0);

        // Contention straight after reset: CPU wins the first tie.
        ack_log.delete();
        t0 = cyc;
        fork
            hold_n(REQ_CPU, 8'h20, NC);
            hold_n(REQ_DMA, 8'h21, ND);
        join
        @(negedge clk);
        build_order(NC, ND);
        check("t2_ack_count", 32'(ack_log.size()), 32'(exp_order.size()));
        if (ack_log.size() > 0) check("t2_first_latency", 32'(ack_log[0].cyc - t0), 2);
        for (int i = 0; i < ack_log.size() && i < exp_order.size(); i++) begin
            check("t2_grant_order", 32'(ack_log[i].port), 32'(exp_order[i]));
            if (i > 0) check("t2_ack_spacing", 32'(ack_log[i].cyc - ack_log[i-1].cyc), 3);
        end

        // CPU write then read back.
        @(negedge clk);
        do_access(REQ_CPU, 1'b1, 8'h10, 8'hA5, 1'b0, lat);
        check("t1_write_latency", 32'(lat), 2);
        @(negedge clk);
        do_access(REQ_CPU, 1'b0, 8'h10, 8'h00, 1'b0, lat);
        check("t1_read_latency", 32'(lat), 2);

        // DMA write stream, one write strobe per access, then CPU reads it.
        @(negedge clk);
        w0 = we_cnt;
        for (int a = 0; a < 4; a++) begin
            do_access(REQ_DMA, 1'b1, 8'(a), 8'(8'hE0 + a * 3), 1'b0, lat);
            check("t3_dma_latency", 32'(lat), 2);
            @(negedge clk);
        end
        check("t3_we_pulses", 32'(we_cnt - w0), 4);
        do_access(REQ_CPU, 1'b0, 8'h02, 8'h00, 1'b0, lat);

        // Request held through the ack counts as a new access.
        @(negedge clk);
        do_access(REQ_CPU, 1'b0, 8'h10, 8'h00, 1'b1, lat);
        check("t5_first_latency", 32'(lat), 2);
        do_access(REQ_CPU, 1'b0, 8'h10, 8'h00, 1'b0, lat);
        check("t5_second_gap", 32'(lat), 3);

        // Reset during the ACCESS cycle of a write aborts it.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h55;
        @(negedge clk);
        check("t4_in_access_we", 32'(mem_we), 1);
        reset = 1'b1;
        #1;
        check("t4_rst_mem_we", 32'(mem_we), 0);
        check("t4_rst_cpu_ack", 32'(cpu_ack), 0);
        check("t4_rst_dma_ack", 32'(dma_ack), 0);
        check("t4_rst_busy", 32'(busy), 0);
        @(negedge clk);
        cpu_req = 1'b0;
        reset   = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        check("t4_post_busy", 32'(busy), 0);
        check("t4_post_cpu_rdata", 32'(cpu_rdata), 0);
        do_access(REQ_CPU, 1'b0, 8'h30, 8'h00, 1'b0, lat);
        check("t4_read_latency", 32'(lat), 2);

        // Randomised concurrent traffic on disjoint address halves.
        @(negedge clk);
        fork
            rand_port(REQ_CPU, 25);
            rand_port(REQ_DMA, 25);
        join
        repeat (6) @(negedge clk);
        check("cpu_queue_drained", 32'(cpu_q.size()), 0);
        check("dma_queue_drained", 32'(dma_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
